// File: rtl/rounding_pipe.sv
// Two-stage significand rounder: four rounding modes, carry renormalisation, overflow to infinity.
// Latency 2 cycles, 1 beat/cycle; a stalled output holds every output stable and backs up into in_ready.
// ROUND_STATS_EN adds saturating 16-bit counters of inexact and overflow transfers.
module rounding_pipe #(
  parameter int MANT_WIDTH  = 23,
  parameter int GUARD_WIDTH = 24,
  parameter int EXP_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          round_mode,
  input  logic                                sign,
  input  logic [EXP_WIDTH-1:0]                exp_in,
  input  logic [MANT_WIDTH+GUARD_WIDTH:0]     value,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                sign_out,
  output logic [EXP_WIDTH-1:0]                exp_out,
  output logic [MANT_WIDTH-1:0]               mant_out,
  output logic                                inexact,
  output logic                                round_up,
  output logic                                overflow,
  output logic [15:0]                         stat_inexact,
  output logic [15:0]                         stat_overflow
);

  localparam int VAL_W = 1 + MANT_WIDTH + GUARD_WIDTH;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH:0]   sig;
    logic                  inc;
    logic                  inexact;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
    logic                  inexact;
    logic                  round_up;
    logic                  overflow;
  } res_t;

  logic s1_vld, s2_vld, s2_load;
  s1_t  s1_d, s1_q;
  res_t res_d, s2_q;

  logic [MANT_WIDTH:0]    in_sig;
  logic [GUARD_WIDTH-1:0] in_g;
  logic                   in_special;

  assign in_sig     = value[VAL_W-1:GUARD_WIDTH];
  assign in_g       = value[GUARD_WIDTH-1:0];
  assign in_special = &exp_in;

  // Stage 1: decide the increment from the guard bits and mode.
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = sign;
    s1_d.exp     = exp_in;
    s1_d.sig     = in_sig;
    s1_d.inexact = |in_g;
    case (round_mode)
      2'b00:   s1_d.inc = 1'b0;
      2'b01:   s1_d.inc = ~sign & s1_d.inexact;
      2'b10:   s1_d.inc = sign & s1_d.inexact;
      default: s1_d.inc = in_g[GUARD_WIDTH-1] & ((|in_g[GUARD_WIDTH-2:0]) | in_sig[0]);
    endcase
    // Inf/NaN: pass the mantissa through untouched.
    if (in_special) begin
      s1_d.inc     = 1'b0;
      s1_d.inexact = 1'b0;
    end
  end

  logic [MANT_WIDTH+1:0] sum;
  logic [EXP_WIDTH-1:0]  exp_inc, exp_post;
  logic [MANT_WIDTH-1:0] mant_post;
  logic                  carry, ovf;

  // Stage 2: apply the increment, renormalise on carry-out, saturate on overflow.
  always_comb begin
    sum       = {1'b0, s1_q.sig} + {{(MANT_WIDTH+1){1'b0}}, s1_q.inc};
    carry     = sum[MANT_WIDTH+1];
    exp_inc   = s1_q.exp + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
    exp_post  = carry ? exp_inc : s1_q.exp;
    mant_post = carry ? sum[MANT_WIDTH:1] : sum[MANT_WIDTH-1:0];
    ovf       = (&exp_post) & ~(&s1_q.exp);

    res_d          = '0;
    res_d.sign     = s1_q.sign;
    res_d.exp      = exp_post;
    res_d.mant     = mant_post;
    res_d.inexact  = s1_q.inexact;
    res_d.round_up = s1_q.inc;
    res_d.overflow = ovf;
    if (ovf) begin
      res_d.exp  = {EXP_WIDTH{1'b1}};
      res_d.mant = '0;
    end
  end

  assign s2_load  = ~s2_vld | out_ready;
  assign in_ready = ~s1_vld | s2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      // Data registers only move on a real beat so a stalled result never changes.
      if (s2_load) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_q <= res_d;
      end
    end
  end

  assign out_valid = s2_vld;
  assign sign_out  = s2_q.sign;
  assign exp_out   = s2_q.exp;
  assign mant_out  = s2_q.mant;
  assign inexact   = s2_q.inexact;
  assign round_up  = s2_q.round_up;
  assign overflow  = s2_q.overflow;

`ifdef ROUND_STATS_EN
  logic [15:0] cnt_inexact, cnt_overflow;
  logic        out_xfer;

  assign out_xfer = s2_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_inexact  <= '0;
      cnt_overflow <= '0;
    end else if (out_xfer) begin
      if (s2_q.inexact && cnt_inexact != 16'hFFFF)   cnt_inexact  <= cnt_inexact + 16'd1;
      if (s2_q.overflow && cnt_overflow != 16'hFFFF) cnt_overflow <= cnt_overflow + 16'd1;
    end
  end

  assign stat_inexact  = cnt_inexact;
  assign stat_overflow = cnt_overflow;
`else
  assign stat_inexact  = 16'h0;
  assign stat_overflow = 16'h0;
`endif

endmodule

// File: tb/tb_rounding_pipe.sv
// Directed bench for rounding_pipe: rounding modes, carry/overflow, specials, backpressure, reset.
module tb_rounding_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  round_mode;
  logic        sign;
  logic [7:0]  exp_in;
  logic [47:0] value;
  logic        out_valid, out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;
  logic        inexact, round_up, overflow;
  logic [15:0] stat_inexact, stat_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int exp_inx_cnt = 0;
  int exp_ovf_cnt = 0;

  always #5 clk = ~clk;

  rounding_pipe #(.MANT_WIDTH(23), .GUARD_WIDTH(24), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .round_mode(round_mode), .sign(sign), .exp_in(exp_in), .value(value),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .inexact(inexact), .round_up(round_up), .overflow(overflow),
    .stat_inexact(stat_inexact), .stat_overflow(stat_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // One beat in, wait for it with a bounded budget, compare every field, then consume it.
  task automatic run_vec(input string tag, input logic [1:0] mode, input logic sgn,
                         input logic [7:0] e, input logic [47:0] val,
                         input logic [7:0] xe, input logic [22:0] xm,
                         input logic xinx, input logic xru, input logic xov);
    int lat;
    round_mode = mode; sign = sgn; exp_in = e; value = val;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; value = 48'hA5A5A5_5A5A5A; exp_in = 8'h33; round_mode = 2'b11; sign = ~sgn;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},   64'(lat), 64'd1);
    check({tag, "_sign"},  64'(sign_out), 64'(sgn));
    check({tag, "_exp"},   64'(exp_out), 64'(xe));
    check({tag, "_mant"},  64'(mant_out), 64'(xm));
    check({tag, "_flags"}, 64'({inexact, round_up, overflow}), 64'({xinx, xru, xov}));
    exp_inx_cnt += int'(xinx);
    exp_ovf_cnt += int'(xov);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  bp_e [5];
    logic [22:0] bp_m [5];
    logic        bp_s [5];
    int acc, got, extra, leaked;
    logic rdy_s, vld_s;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    round_mode = 2'b00; sign = 1'b0; exp_in = 8'h0; value = 48'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_ovld",  64'(out_valid), 64'd0);
    check("rst_irdy",  64'(in_ready), 64'd1);
    check("rst_data",  64'({sign_out, exp_out, mant_out}), 64'd0);
    check("rst_flags", 64'({inexact, round_up, overflow}), 64'd0);
    check("rst_stats", 64'({stat_inexact, stat_overflow}), 64'd0);
    @(posedge clk); #1;

    //       tag        mode  s     exp    value             exp    mant        inx  ru   ov
    run_vec("rne_tie0", 2'b11, 1'b0, 8'h7F, 48'h800000_800000, 8'h7F, 23'h000000, 1'b1, 1'b0, 1'b0);
    run_vec("rne_tie1", 2'b11, 1'b0, 8'h7F, 48'h800001_800000, 8'h7F, 23'h000002, 1'b1, 1'b1, 1'b0);
    run_vec("rne_low",  2'b11, 1'b0, 8'h7F, 48'h800000_7FFFFF, 8'h7F, 23'h000000, 1'b1, 1'b0, 1'b0);
    run_vec("carry",    2'b11, 1'b0, 8'h7F, 48'hFFFFFF_FFFFFF, 8'h80, 23'h000000, 1'b1, 1'b1, 1'b0);
    run_vec("ovf",      2'b01, 1'b0, 8'hFE, 48'hFFFFFF_000001, 8'hFF, 23'h000000, 1'b1, 1'b1, 1'b1);
    run_vec("ovf_rtz",  2'b00, 1'b0, 8'hFE, 48'hFFFFFF_000001, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 1'b0);
    run_vec("neg_rm",   2'b10, 1'b1, 8'h7F, 48'h800000_000001, 8'h7F, 23'h000001, 1'b1, 1'b1, 1'b0);
    run_vec("neg_rp",   2'b01, 1'b1, 8'h7F, 48'h800000_000001, 8'h7F, 23'h000000, 1'b1, 1'b0, 1'b0);
    run_vec("pos_rm",   2'b10, 1'b0, 8'h7F, 48'h800000_000001, 8'h7F, 23'h000000, 1'b1, 1'b0, 1'b0);
    run_vec("exact_rn", 2'b11, 1'b0, 8'h40, 48'h812345_000000, 8'h40, 23'h012345, 1'b0, 1'b0, 1'b0);
    run_vec("exact_rp", 2'b01, 1'b0, 8'h40, 48'h812345_000000, 8'h40, 23'h012345, 1'b0, 1'b0, 1'b0);
    run_vec("exact_rm", 2'b10, 1'b1, 8'h40, 48'h812345_000000, 8'h40, 23'h012345, 1'b0, 1'b0, 1'b0);
    run_vec("denorm",   2'b11, 1'b0, 8'h00, 48'h7FFFFF_C00000, 8'h00, 23'h000000, 1'b1, 1'b1, 1'b0);
    run_vec("inf_pass", 2'b01, 1'b0, 8'hFF, 48'hFFFFFF_FFFFFF, 8'hFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b0);
    run_vec("nan_pass", 2'b11, 1'b1, 8'hFF, 48'h8ABCDE_123456, 8'hFF, 23'h0ABCDE, 1'b0, 1'b0, 1'b0);

`ifdef ROUND_STATS_EN
    check("stat_inx", 64'(stat_inexact),  64'(exp_inx_cnt));
    check("stat_ovf", 64'(stat_overflow), 64'(exp_ovf_cnt));
`else
    check("stat_inx", 64'(stat_inexact),  64'd0);
    check("stat_ovf", 64'(stat_overflow), 64'd0);
`endif

    // Backpressure: five back-to-back beats, consumer stalled for the first four cycles.
    for (int k = 0; k < 5; k++) begin
      bp_e[k] = 8'(8'h10 + k);
      bp_m[k] = 23'(23'h100000 + k);
      bp_s[k] = k[0];
    end
    acc = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = (c >= 4);
      if (acc < 5) begin
        in_valid = 1'b1; round_mode = 2'b00; sign = bp_s[acc];
        exp_in = bp_e[acc]; value = {1'b1, bp_m[acc], 24'h0};
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("bp_acc2", 64'(acc), 64'd2);
      if (c == 2 || c == 3) begin
        check("bp_stall_rdy", 64'(in_ready), 64'd0);
        check("bp_stall_vld", 64'(out_valid), 64'd1);
        check("bp_stall_dat", 64'({sign_out, exp_out, mant_out}), 64'({bp_s[0], bp_e[0], bp_m[0]}));
      end
      if (out_valid && out_ready) begin
        check("bp_order", 64'({sign_out, exp_out, mant_out, inexact, round_up, overflow}),
              64'({bp_s[got], bp_e[got], bp_m[got], 3'b000}));
        got++;
      end
      rdy_s = in_ready; vld_s = in_valid;
      @(posedge clk);
      if (vld_s && rdy_s) acc++;
      #1;
    end
    in_valid = 1'b0;
    check("bp_count", 64'(got), 64'd5);
    extra = 0;
    repeat (4) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    check("bp_dup", 64'(extra), 64'd0);

    // Reset with two inexact beats in flight: neither may emerge afterwards.
    out_ready = 1'b0;
    in_valid = 1'b1; round_mode = 2'b01; sign = 1'b0; exp_in = 8'h20; value = 48'h800000_FFFFFF;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ovld", 64'(out_valid), 64'd0);
    check("midrst_irdy", 64'(in_ready), 64'd1);
    rst = 1'b0; out_ready = 1'b1;
    leaked = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) leaked++;
    end
    check("midrst_leak", 64'(leaked), 64'd0);
    check("midrst_stats", 64'({stat_inexact, stat_overflow}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rounding_pipe.md
# rounding_pipe

Pipelined, parametrised successor to the combinational mantissa rounder in the real multiplier datapath. The block takes a normalised product significand with a hidden bit, guard bits, an exponent and a sign. It rounds in one of four modes, renormalises on carry-out, increments the exponent and saturates to infinity on overflow. It sits between the significand multiplier and result packing, with valid/ready handshakes on both sides and full backpressure support.

## Interface
- MANT_WIDTH, 23: stored mantissa width; 52 for double.
- GUARD_WIDTH, 24: discarded low bits used for rounding; 53 for double.
- EXP_WIDTH, 8: biased exponent width; 11 for double.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- round_mode  in  2  rounding mode: 00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even.
- sign  in  1  sign of the value.
- exp_in  in  EXP_WIDTH  biased exponent.
- value  in  1+MANT_WIDTH+GUARD_WIDTH  {hidden bit, mantissa, guard bits}; hidden bit is 1 for normal inputs.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sign_out  out  1  sign, passed through.
- exp_out  out  EXP_WIDTH  result exponent.
- mant_out  out  MANT_WIDTH  rounded mantissa, hidden bit dropped.
- inexact  out  1  guard bits were nonzero.
- round_up  out  1  an increment was applied.
- overflow  out  1  result saturated to infinity.
- stat_inexact  out  16  count of inexact results; see Configuration.
- stat_overflow  out  16  count of overflow results; see Configuration.

## Operation
- Split the input: sig = value[top:GUARD_WIDTH], which is MANT_WIDTH+1 bits; g = value[GUARD_WIDTH-1:0].
- Set inexact = |g.
- Compute inc by mode:
  - 00: 0.
  - 01: !sign & inexact.
  - 10: sign & inexact.
  - 11: g[msb] & (|g[msb-1:0] | sig[0]).
- Stage 1 registers sign, exp, sig, inc and inexact.
- Stage 2 computes sum = sig + inc at MANT_WIDTH+2 bits.
  - If sum[MANT_WIDTH+1] is set (carry-out): mant = sum[MANT_WIDTH:1] (all zero) and exp = exp_in+1.
  - Otherwise mant = sum[MANT_WIDTH-1:0] and exp = exp_in.
- Overflow: the post-round exp equals all-ones while exp_in did not.
  - Output exp = all-ones, mant = 0, overflow = 1.
  - Infinity is the correct result: an increment only occurs in modes rounding toward the value's sign.
- Special input: exp_in all-ones (inf/NaN) passes through with mant = value[MANT_WIDTH+GUARD_WIDTH-1:GUARD_WIDTH] and inc forced to 0. inexact, round_up and overflow are all 0.
- Zero or denormal input (exp_in = 0) is rounded with the same rules; there is no underflow handling.
- round_up = inc, registered alongside the result.

## Timing
- Latency is 2 cycles: a beat accepted at edge N appears with out_valid at edge N+2 when not stalled.
- Throughput is 1 beat per cycle.
- A transfer occurs when valid & ready are both high on an edge. Results leave in acceptance order.
- Each stage holds a valid bit.
  - Stage 2 loads when empty or out_ready = 1.
  - Stage 1 loads when empty or stage 2 loads.
  - in_ready = !s1_valid | s2_load.
  - in_ready may depend combinationally on out_ready.
- While out_valid = 1 and out_ready = 0, every output holds stable.
- With out_ready held low, at most 2 beats are buffered. in_ready falls in the cycle after the second accept.
- Reset values: out_valid 0, in_ready 1 from the first cycle after reset, all data and flag outputs 0, stat counters 0.
- Reset mid-operation discards both in-flight beats. No partial result appears after reset.
- Inputs other than in_valid are ignored when in_valid = 0.

## Configuration
- ROUND_STATS_EN defined:
  - stat_inexact and stat_overflow count output transfers with inexact = 1 and overflow = 1 respectively.
  - Counters saturate at 16'hFFFF and clear on rst.
- ROUND_STATS_EN undefined: both ports are tied to 0 and no counter logic is generated.

## Test plan
- Round to nearest, ties to even, default widths: mode 11, exp 8'h7F.
  - value 48'h800000_800000 -> mant 23'h0, round_up 0, inexact 1.
  - value 48'h800001_800000 -> mant 23'h2, round_up 1.
- Carry renormalisation: mode 11, exp 8'h7F, value 48'hFFFFFF_FFFFFF -> exp 8'h80, mant 0, round_up 1, overflow 0.
- Overflow: mode 01, sign 0, exp 8'hFE, value 48'hFFFFFF_000001 -> exp 8'hFF, mant 0, overflow 1.
  - Same input with mode 00 -> exp 8'hFE, mant 23'h7FFFFF, inexact 1, overflow 0.
- Directed modes on exact and inexact inputs.
  - sign 1, mode 10, value 48'h800000_000001 -> mant 1.
  - sign 1, mode 01 -> mant 0.
  - g = 0 in any mode -> inexact 0, round_up 0.
- Backpressure: stream 5 back-to-back beats while out_ready = 0 for 4 cycles.
  - in_ready drops after 2 accepts.
  - All 5 results emerge in order with no duplicates.
  - Outputs stay stable while stalled.
- Reset and special inputs.
  - Assert rst with 2 beats in flight -> out_valid 0 the next cycle, and nothing from those beats appears later.
  - Input exp 8'hFF -> passthrough with all flags 0.
  - With ROUND_STATS_EN defined, the counters match the bench-counted inexact and overflow totals.
